// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALU_W / ALU_OPW : default operand and opcode widths
//   - OP_*            : ALU opcodes, which the arbiter forwards unchanged
//   - state_t         : arbiter FSM states (IDLE, BUSY)
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_OPW = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bundle of the ALU arbiter.
//   req_valid/req_ready : per-port request handshake
//   req_a*/req_b*/req_op*: operands and opcode of port 0/1
//   rsp_valid/rsp_ready : per-port response handshake
//   rsp_r/rsp_z/rsp_v/rsp_c : registered result and flags, shared by both ports
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   req_a0;
  logic [W-1:0]   req_a1;
  logic [W-1:0]   req_b0;
  logic [W-1:0]   req_b1;
  logic [OPW-1:0] req_op0;
  logic [OPW-1:0] req_op1;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_r;
  logic           rsp_z;
  logic           rsp_v;
  logic           rsp_c;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, rsp_c
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_z, rsp_v, rsp_c
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-requester arbiter.
//   req  : request vector
//   ptr  : round-robin pointer (port that wins when both request)
//   gnt  : one-hot grant (all zero when nothing requests)
//   win  : encoded winner (0 when nothing requests)
// Build option: ALU_ARB_FIXED_PRIO_EN makes port 0 win every tie and ptr is ignored.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       win
);

  // Winner selection: a lone requester always wins, ties go to ptr (or port 0).
  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    case (req)
      2'b01: begin
        gnt = 2'b01;
        win = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        win = 1'b1;
      end
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = 1'b0;
`else
        win = ptr;
`endif
        if (win) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: begin
        gnt = 2'b00;
        win = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
//   clk, rst_n              : clock (rising edge), async active-low reset
//   bus (alu_arbiter_if)    : request/response handshakes of ports 0 and 1
//   alu_a, alu_b, alu_op    : operands/opcode to the shared ALU (zero unless a grant is live)
//   alu_r, alu_z/v/c        : ALU result and flags, captured on request acceptance
// An accepted request moves IDLE->BUSY; the response is held until the owning
// port takes it, so at most one operation completes every two cycles.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority, no pointer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_r,
  input  logic           alu_z,
  input  logic           alu_v,
  input  logic           alu_c
);

  state_t       state_r;
  logic         owner_r;
  logic [1:0]   rsp_valid_r;
  logic [W-1:0] rsp_r_r;
  logic         rsp_z_r;
  logic         rsp_v_r;
  logic         rsp_c_r;
  logic [1:0]   gnt_s;
  logic         win_s;
  logic         ptr_s;
  logic         idle_s;
  logic         accept_s;
  logic         rsp_done_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr_s = 1'b0;
`else
  logic         ptr_r;
  assign ptr_s = ptr_r;
`endif

  rr_arb2 u_arb (
    .req (bus.req_valid),
    .ptr (ptr_s),
    .gnt (gnt_s),
    .win (win_s)
  );

  assign idle_s     = (state_r == ST_IDLE);
  // Grant is only ever offered to a valid port, so this reduces to "winner is valid".
  assign accept_s   = idle_s && ((gnt_s & bus.req_valid) != 2'b00);
  assign rsp_done_s = (state_r == ST_BUSY) && bus.rsp_ready[owner_r];

  assign bus.req_ready = idle_s ? gnt_s : 2'b00;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_r     = rsp_r_r;
  assign bus.rsp_z     = rsp_z_r;
  assign bus.rsp_v     = rsp_v_r;
  assign bus.rsp_c     = rsp_c_r;

  // Operand mux: the granted port drives the ALU while IDLE, otherwise all zeros.
  always_comb begin
    alu_a  = {W{1'b0}};
    alu_b  = {W{1'b0}};
    alu_op = {OPW{1'b0}};
    if (idle_s && (gnt_s != 2'b00)) begin
      if (win_s) begin
        alu_a  = bus.req_a1;
        alu_b  = bus.req_b1;
        alu_op = bus.req_op1;
      end else begin
        alu_a  = bus.req_a0;
        alu_b  = bus.req_b0;
        alu_op = bus.req_op0;
      end
    end else begin
      alu_a  = {W{1'b0}};
      alu_b  = {W{1'b0}};
      alu_op = {OPW{1'b0}};
    end
  end

  // FSM with response, owner and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
      rsp_r_r     <= {W{1'b0}};
      rsp_z_r     <= 1'b0;
      rsp_v_r     <= 1'b0;
      rsp_c_r     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_BUSY;
            owner_r     <= win_s;
            rsp_valid_r <= gnt_s;
            rsp_r_r     <= alu_r;
            rsp_z_r     <= alu_z;
            rsp_v_r     <= alu_v;
            rsp_c_r     <= alu_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_r       <= ~win_s;
`endif
          end
        end
        ST_BUSY: begin
          // Only the owner's rsp_ready retires the response; the other port is ignored.
          if (rsp_done_s) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 2'b00;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter, with a
// behavioural ALU (z = result==0, ADD/SUB carry and signed overflow).
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_op;
  logic        alu_z, alu_v, alu_c;
  logic [32:0] sum;
  int          n_cmp;
  int          n_fail;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_r  (alu_r),
    .alu_z  (alu_z),
    .alu_v  (alu_v),
    .alu_c  (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    sum   = 33'd0;
    alu_r = 32'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_ADD: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = sum[31:0];
        alu_c = sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      OP_SUB: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_r = sum[31:0];
        alu_c = sum[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      OP_SLT: alu_r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_NOR: alu_r = ~(alu_a | alu_b);
      default: alu_r = 32'd0;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_a0 = 32'd0; bus.req_a1 = 32'd0; bus.req_b0 = 32'd0; bus.req_b1 = 32'd0;
    bus.req_op0 = 4'd0; bus.req_op1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    if (bus.req_ready !== 2'b00) begin $display("FAIL rst_req_ready got %b want 00", bus.req_ready); n_fail++; end n_cmp++;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL rst_rsp_valid got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
    if ({bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c} !== 35'd0) begin $display("FAIL rst_rsp got %h/%b%b%b want 0", bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c); n_fail++; end n_cmp++;
    if ({alu_a, alu_b, alu_op} !== 68'd0) begin $display("FAIL rst_alu got %h %h %h want 0", alu_a, alu_b, alu_op); n_fail++; end n_cmp++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_port0_add();
    bus.req_valid = 2'b01; bus.req_a0 = 32'd7; bus.req_b0 = 32'd5; bus.req_op0 = OP_ADD;
    #1;
    if (bus.req_ready !== 2'b01) begin $display("FAIL add_ready got %b want 01", bus.req_ready); n_fail++; end n_cmp++;
    if ({alu_a, alu_b, alu_op} !== {32'd7, 32'd5, OP_ADD}) begin $display("FAIL add_alu_in got %h %h %h want 7 5 2", alu_a, alu_b, alu_op); n_fail++; end n_cmp++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (bus.rsp_valid !== 2'b01) begin $display("FAIL add_rsp_valid got %b want 01", bus.rsp_valid); n_fail++; end n_cmp++;
    if (bus.rsp_r !== 32'd12) begin $display("FAIL add_r got %h want 0000000c", bus.rsp_r); n_fail++; end n_cmp++;
    if ({bus.rsp_z, bus.rsp_v, bus.rsp_c} !== 3'b000) begin $display("FAIL add_flags got %b%b%b want 000", bus.rsp_z, bus.rsp_v, bus.rsp_c); n_fail++; end n_cmp++;
    if ({alu_a, alu_op} !== 36'd0) begin $display("FAIL add_busy_alu got %h %h want 0", alu_a, alu_op); n_fail++; end n_cmp++;
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL add_done got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
  endtask

  task automatic test_port1_sub_hold();
    bus.req_valid = 2'b10; bus.req_a1 = 32'h8000_0000; bus.req_b1 = 32'd1; bus.req_op1 = OP_SUB;
    #1;
    if (bus.req_ready !== 2'b10) begin $display("FAIL sub_ready got %b want 10", bus.req_ready); n_fail++; end n_cmp++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.req_a1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 2'b10) begin $display("FAIL sub_hold_valid[%0d] got %b want 10", i, bus.rsp_valid); n_fail++; end n_cmp++;
      if ({bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c} !== {32'h7FFF_FFFF, 3'b011}) begin $display("FAIL sub_hold_rsp[%0d] got %h %b%b%b want 7fffffff 011", i, bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c); n_fail++; end n_cmp++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL sub_done got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
  endtask

  task automatic test_both_rr();
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    bus.req_valid = 2'b11;
    bus.req_a0 = 32'd1;    bus.req_b0 = 32'd2;    bus.req_op0 = OP_ADD;
    bus.req_a1 = 32'h10;   bus.req_b1 = 32'h01;   bus.req_op1 = OP_OR;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = ((i % 2) == 1) ? 2'b10 : 2'b01;
`endif
      exp_r = (exp_g == 2'b01) ? 32'd3 : 32'h11;
      #1;
      if (bus.req_ready !== exp_g) begin $display("FAIL rr_grant[%0d] got %b want %b", i, bus.req_ready, exp_g); n_fail++; end n_cmp++;
      @(posedge clk); #1;
      if (bus.rsp_valid !== exp_g) begin $display("FAIL rr_rsp_valid[%0d] got %b want %b", i, bus.rsp_valid, exp_g); n_fail++; end n_cmp++;
      if (bus.rsp_r !== exp_r) begin $display("FAIL rr_r[%0d] got %h want %h", i, bus.rsp_r, exp_r); n_fail++; end n_cmp++;
      bus.rsp_ready = 2'b11;
      @(posedge clk); #1;
      bus.rsp_ready = 2'b00;
      // Response retired while both requests stay valid: nothing accepted on that edge.
      if (bus.rsp_valid !== 2'b00) begin $display("FAIL rr_no_same_cycle[%0d] got %b want 00", i, bus.rsp_valid); n_fail++; end n_cmp++;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_and_busy();
    bus.req_valid = 2'b01; bus.req_a0 = 32'hF0F0_F0F0; bus.req_b0 = 32'h0F0F_0F0F; bus.req_op0 = OP_AND;
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.req_ready !== 2'b00) begin $display("FAIL and_busy_ready[%0d] got %b want 00", i, bus.req_ready); n_fail++; end n_cmp++;
      if ({bus.rsp_r, bus.rsp_z} !== {32'd0, 1'b1}) begin $display("FAIL and_rsp[%0d] got %h z=%b want 0 z=1", i, bus.rsp_r, bus.rsp_z); n_fail++; end n_cmp++;
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL and_done got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
  endtask

  task automatic test_reset_busy();
    bus.req_valid = 2'b01; bus.req_a0 = 32'd3; bus.req_b0 = 32'd4; bus.req_op0 = OP_ADD;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (bus.rsp_valid !== 2'b01) begin $display("FAIL rb_pre got %b want 01", bus.rsp_valid); n_fail++; end n_cmp++;
    rst_n = 1'b0;
    #1;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL rb_async_valid got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
    if (bus.rsp_r !== 32'd0) begin $display("FAIL rb_async_r got %h want 0", bus.rsp_r); n_fail++; end n_cmp++;
    #2;
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a1 = 32'd9; bus.req_b1 = 32'd9; bus.req_op1 = OP_ADD;
    #1;
    if (bus.req_ready !== 2'b01) begin $display("FAIL rb_ptr_grant got %b want 01", bus.req_ready); n_fail++; end n_cmp++;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (bus.rsp_valid !== 2'b01) begin $display("FAIL rb_rsp_valid got %b want 01", bus.rsp_valid); n_fail++; end n_cmp++;
    if (bus.rsp_r !== 32'd7) begin $display("FAIL rb_r got %h want 7", bus.rsp_r); n_fail++; end n_cmp++;
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_nor_wrong_ready();
    bus.req_valid = 2'b01; bus.req_a0 = 32'd0; bus.req_b0 = 32'd0; bus.req_op0 = OP_NOR;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid !== 2'b01) begin $display("FAIL nor_hold_valid[%0d] got %b want 01", i, bus.rsp_valid); n_fail++; end n_cmp++;
      if ({bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c} !== {32'hFFFF_FFFF, 3'b000}) begin $display("FAIL nor_rsp[%0d] got %h %b%b%b want ffffffff 000", i, bus.rsp_r, bus.rsp_z, bus.rsp_v, bus.rsp_c); n_fail++; end n_cmp++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    if (bus.rsp_valid !== 2'b00) begin $display("FAIL nor_done got %b want 00", bus.rsp_valid); n_fail++; end n_cmp++;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_port0_add();
    test_port1_sub_hold();
    test_both_rr();
    test_and_busy();
    test_reset_busy();
    test_nor_wrong_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit combinational `alu` between two requesters (e.g. the execute stage and a branch/address unit) using valid/ready handshakes. Each port submits operand A, operand B and a 4-bit ALU opcode. The block arbitrates round-robin, drives the shared ALU and captures its result and flags into a response register. It then returns the response to the granted port only.

## Interface
Parameters:
- `W`, 32, operand/result width
- `OPW`, 4, opcode width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid[1:0]`  in  2  per-port request valid
- `req_ready[1:0]`  out  2  per-port request accept
- `req_a0`, `req_a1`  in  W  operand A, port 0/1
- `req_b0`, `req_b1`  in  W  operand B, port 0/1
- `req_op0`, `req_op1`  in  OPW  opcode, port 0/1
- `rsp_valid[1:0]`  out  2  per-port response valid
- `rsp_ready[1:0]`  in  2  per-port response accept
- `rsp_r`  out  W  registered ALU result, shared by both ports
- `rsp_z`, `rsp_v`, `rsp_c`  out  1  registered ALUz, overflow and carry flags
- `alu_a`, `alu_b`  out  W  operands to the shared ALU
- `alu_op`  out  OPW  opcode to the shared ALU
- `alu_r`  in  W  ALU result
- `alu_z`, `alu_v`, `alu_c`  in  1  ALU flags

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- In IDLE:
  - The grant `g` is chosen from `req_valid` by the arbiter.
  - `req_ready[g]=1`; the other `req_ready` bit is 0.
  - `alu_a/alu_b/alu_op` are driven combinationally from port `g`.
- Acceptance happens when `req_valid[g] & req_ready[g]`. On that edge:
  - `alu_r/z/v/c` are captured into `rsp_*`.
  - `owner<=g`.
  - The round-robin pointer is set to `~g`.
  - The FSM moves to BUSY.
- In BUSY:
  - `req_ready=2'b00`.
  - `rsp_valid[owner]=1`.
  - `alu_a/alu_b/alu_op` are driven to 0.
  - `rsp_*` hold stable until `rsp_ready[owner]`, then the FSM returns to IDLE.
- Round-robin rule:
  - Only one port valid: that port wins.
  - Both valid: the port selected by the pointer wins.
  - Pointer reset value: port 0.
- Opcodes are forwarded unchanged. AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100. Any other code is passed through, and the result is whatever the ALU returns.
- A requester may drop `req_valid` before acceptance without side effects. The pointer advances only on acceptance.
- `rsp_ready` on the non-owner port is ignored.

## Timing
- Reset values of all outputs:
  - `req_ready=0`, `rsp_valid=0`.
  - `rsp_r=0`, `rsp_z=0`, `rsp_v=0`, `rsp_c=0`.
  - `alu_a=0`, `alu_b=0`, `alu_op=0`.
- Latency: request accepted at edge N gives `rsp_valid` high during cycle N+1.
- Throughput: at most one operation per 2 cycles (accept, then respond).
- ALU path: the ALU is combinational, so request to `alu_*` to capture is a single-cycle path.
- `req_ready` depends combinationally on `req_valid` and state. It never depends on `rsp_ready`.
- Reset asserted mid-operation: the BUSY response is discarded, the FSM goes to IDLE and the pointer returns to port 0, all immediately and asynchronously.
- Simultaneous events: a response handshake in BUSY and a new request both present in the same cycle. The new request is accepted in the following IDLE cycle, never in the same cycle.

## Configuration
- Macro: `ALU_ARB_FIXED_PRIO_EN`.
- Defined: port 0 always wins when both ports are valid, and the pointer register is removed.
- Undefined (default): round-robin as described in Operation.

## Structure
- `alu_pkg` holds:
  - the opcode localparams (AND, OR, ADD, SUB, SLT, NOR);
  - the default width of 32;
  - the FSM state enum (IDLE, BUSY).
- Sub-module `rr_arb2`:
  - inputs: 2-bit request vector, pointer;
  - outputs: one-hot grant and encoded winner;
  - contains the `ALU_ARB_FIXED_PRIO_EN` switch.
- Top level: FSM, response/owner registers, operand mux.

## Test plan
- Port 0 only: ADD A=7, B=5 -> `rsp_valid[0]` one cycle after accept, `rsp_r=12`, `rsp_v=0`, `rsp_valid[1]=0`.
- Port 1 only: SUB A=0x80000000, B=1 -> `rsp_r=0x7FFFFFFF`, `rsp_v=1`; `rsp_*` stable while `rsp_ready[1]=0` for 5 cycles.
- Both ports hold `req_valid` for 4 operations -> grants 0,1,0,1; with `ALU_ARB_FIXED_PRIO_EN` -> 0,0,0,0.
- Port 0 AND A=0xF0F0F0F0, B=0x0F0F0F0F -> `rsp_r=0`, `rsp_z` equals the ALU's `alu_z` for that op; `req_ready=0` throughout BUSY.
- `rst_n` pulsed low while BUSY -> `rsp_valid=0` at once; next simultaneous request is granted to port 0.
- Port 0 NOR A=0, B=0 with `rsp_ready[1]` held high and `rsp_ready[0]` low -> the response is not consumed and the FSM stays BUSY.
